multi_issue_queue: RTL and testbench
====================================

MULTI_ISSUE_QUEUE -- requirements
Module: multi_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue entries; power of two, 2..32.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 2: max instructions issued per cycle; 1 or 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: opaque payload bits per entry.
REQ-004 SHALL have parameter NR_FU, default 4: number of functional-unit classes.
REQ-005 SHALL have clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have flush_i, input, 1: discard all queued entries.
REQ-008 SHALL have enq_valid_i / enq_ready_o, input / output, 1 each: enqueue handshake; transfer when both high.
REQ-009 SHALL have enq_data_i, input, DATA_WIDTH: payload.
REQ-010 SHALL have enq_rd_i, enq_rs1_i, enq_rs2_i, input, 5 each: destination and source register addresses.
REQ-011 SHALL have enq_we_i, input, 1: instruction writes rd.
REQ-012 SHALL have enq_fu_i, input, $clog2(NR_FU): target FU class.
REQ-013 SHALL have rd_busy_i, input, 32: per-register pending-write bitmap from scoreboard.
REQ-014 SHALL have fu_ready_i, input, NR_FU: per-class FU ready.
REQ-015 SHALL have issue_valid_o, output, ISSUE_WIDTH: slot k consumed and issued this cycle.
REQ-016 SHALL have issue_data_o, issue_rd_o, issue_we_o, issue_fu_o, output, ISSUE_WIDTH x field width: issued entry fields.
REQ-017 SHALL have count_o, output, $clog2(DEPTH+1): occupied entries.
REQ-018 SHALL have stall_o, output, 1: queue non-empty and zero instructions issued this cycle.

Function
REQ-019 SHALL be a circular in-order buffer: write pointer, read pointer, registered count; pointers wrap modulo DEPTH.
REQ-020 SHALL drive enq_ready_o = (count_o < DEPTH) and not flush_i; slots freed by same-cycle issue are not reusable until next cycle.
REQ-021 SHALL present the ISSUE_WIDTH oldest entries as candidate slots 0..ISSUE_WIDTH-1; slot k exists only if count_o > k.
REQ-022 SHALL issue slot 0 when: present, rs1 and rs2 not busy in rd_busy_i, fu_ready_i[fu] high.
REQ-023 SHALL issue slot 1 only when slot 0 issues and slot 1 meets REQ-022 and: rs1/rs2 differ from slot-0 rd when slot-0 we, rd differs from slot-0 rd when both we, fu differs from slot-0 fu.
REQ-024 SHALL treat register x0 as never busy and never hazarding (source or destination).
REQ-025 SHALL issue combinationally (0-cycle) from queue head; issue_valid_o is the only FU handshake, no back-pressure after issue.
REQ-026 SHALL advance read pointer by number of issued slots; count_o(next) = count + enqueued - issued.
REQ-027 SHALL drive issue_data_o/rd/we/fu of non-issued slots to zero.
REQ-028 On flush_i: SHALL force issue_valid_o to 0, ignore enqueue, and set pointers and count to 0 next cycle.
REQ-029 Enqueue into a full queue SHALL not occur; enq_valid_i high with enq_ready_o low SHALL leave state unchanged.

Reset
REQ-030 With rst_i high at a clock edge: pointers 0, count_o 0, entries invalid; during reset issue_valid_o, stall_o, enq_ready_o 0.
REQ-031 Reset mid-operation SHALL discard all entries, same as REQ-030; first enqueue accepted on the cycle after rst_i falls.

Configuration
REQ-032 With ISSUE_QUEUE_BYPASS_EN defined: when count_o is 0 and not flushing, the incoming enqueue SHALL act as slot 0 candidate the same cycle; if issued it SHALL not be written, count unchanged.
REQ-033 Without ISSUE_QUEUE_BYPASS_EN: minimum enqueue-to-issue latency SHALL be 1 cycle; issue only from stored entries.

Verification
REQ-034 Reset, then enqueue 8 independent ALU/LSU-alternating entries, all FUs ready -> two issues per cycle, count_o 8->0 in 4 cycles after fill.
REQ-035 Slot0 rd=x5 we=1, slot1 rs1=x5 -> only slot0 issues; slot1 issues next cycle as slot0.
REQ-036 Slot0 rd=x0 we=1, slot1 rs1=x0, different FUs -> both issue same cycle.
REQ-037 Fill to DEPTH=8, hold fu_ready_i=0 -> enq_ready_o 0, stall_o 1; raise fu_ready -> enq_ready_o 1 the following cycle.
REQ-038 Queue count 5, assert flush_i with enq_valid_i high -> issue_valid_o 0 that cycle, count_o 0 next cycle, enqueue dropped.
REQ-039 Bypass build, empty queue, enqueue ready instruction -> issue_valid_o[0]=1 same cycle, count_o stays 0; non-bypass build -> issue one cycle later.

Source files
------------

// File: rtl/multi_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_issue_queue_if
// Description : Enqueue handshake and issue bus of the multi-issue queue.
//               The slave modport is the queue; the master modport is the
//               front end that enqueues and the functional units that
//               receive issued instructions.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_issue_queue_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int NR_FU       = 4
);
    localparam int c_fu_w = (NR_FU > 1) ? $clog2(NR_FU) : 1;

    // enqueue side
    logic                                  enq_valid_i;
    logic                                  enq_ready_o;
    logic [DATA_WIDTH-1:0]                 enq_data_i;
    logic [4:0]                            enq_rd_i;
    logic [4:0]                            enq_rs1_i;
    logic [4:0]                            enq_rs2_i;
    logic                                  enq_we_i;
    logic [c_fu_w-1:0]                     enq_fu_i;

    // issue side
    logic [ISSUE_WIDTH-1:0]                issue_valid_o;
    logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] issue_data_o;
    logic [ISSUE_WIDTH-1:0][4:0]           issue_rd_o;
    logic [ISSUE_WIDTH-1:0]                issue_we_o;
    logic [ISSUE_WIDTH-1:0][c_fu_w-1:0]    issue_fu_o;

    modport master (
        output enq_valid_i, enq_data_i, enq_rd_i, enq_rs1_i, enq_rs2_i,
               enq_we_i, enq_fu_i,
        input  enq_ready_o,
        input  issue_valid_o, issue_data_o, issue_rd_o, issue_we_o, issue_fu_o
    );

    modport slave (
        input  enq_valid_i, enq_data_i, enq_rd_i, enq_rs1_i, enq_rs2_i,
               enq_we_i, enq_fu_i,
        output enq_ready_o,
        output issue_valid_o, issue_data_o, issue_rd_o, issue_we_o, issue_fu_o
    );
endinterface
`default_nettype wire

// File: rtl/multi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : multi_issue_queue
// Description : In-order circular issue queue. The one or two oldest entries
//               are issue candidates; they leave the queue combinationally
//               when their sources are not pending in the scoreboard, their
//               FU class is ready and (for slot 1) no hazard exists against
//               slot 0. Optional build macro ISSUE_QUEUE_BYPASS_EN lets an
//               enqueue into an empty queue issue in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_issue_queue #(
    parameter int DEPTH       = 8,
    parameter int ISSUE_WIDTH = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int NR_FU       = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [31:0]                 rd_busy_i,
    input  logic [NR_FU-1:0]            fu_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic                        stall_o,
    multi_issue_queue_if.slave          bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_fu_w  = (NR_FU > 1) ? $clog2(NR_FU) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_depth = c_cnt_w'(DEPTH);

    // entry storage; validity is implied by the pointers and count
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [4:0]            rs1_q  [DEPTH];
    logic [4:0]            rs2_q  [DEPTH];
    logic                  we_q   [DEPTH];
    logic [c_fu_w-1:0]     fu_q   [DEPTH];

    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]    count_q,  count_d;

    // candidate slots (always two internally; slot 1 unused in single issue)
    logic [DATA_WIDTH-1:0] w_c_data [2];
    logic [4:0]            w_c_rd   [2];
    logic [4:0]            w_c_rs1  [2];
    logic [4:0]            w_c_rs2  [2];
    logic                  w_c_we   [2];
    logic [c_fu_w-1:0]     w_c_fu   [2];
    logic [1:0]            w_c_pres;
    logic [1:0]            w_c_rdy;

    logic                  w_live;
    logic                  w_byp;
    logic                  w_enq_ready;
    logic                  w_enq_wr;
    logic                  w_hazard1;
    logic [1:0]            w_iss;
    logic [c_cnt_w-1:0]    w_pop_cnt;
    logic [c_ptr_w-1:0]    w_idx1;

    // a source register is free when it is x0 or not pending a write
    function automatic logic src_free(input logic [4:0] r, input logic [31:0] busy);
        return (r == 5'd0) || !busy[r];
    endfunction

    assign w_live      = !rst_i && !flush_i;
    assign w_enq_ready = w_live && (count_q < c_cnt_depth);
    assign w_idx1      = rd_ptr_q + c_ptr_w'(1);

`ifdef ISSUE_QUEUE_BYPASS_EN
    // an empty queue offers the incoming instruction as slot 0 directly
    assign w_byp = w_live && (count_q == '0) && bus.enq_valid_i;
`else
    assign w_byp = 1'b0;
`endif

    // select candidate fields from the queue head or the bypassed enqueue
    always_comb begin
        w_c_pres[0] = (count_q != '0) || w_byp;
        w_c_pres[1] = (count_q > c_cnt_w'(1));
        if (w_byp) begin
            w_c_data[0] = bus.enq_data_i;
            w_c_rd[0]   = bus.enq_rd_i;
            w_c_rs1[0]  = bus.enq_rs1_i;
            w_c_rs2[0]  = bus.enq_rs2_i;
            w_c_we[0]   = bus.enq_we_i;
            w_c_fu[0]   = bus.enq_fu_i;
        end else begin
            w_c_data[0] = data_q[rd_ptr_q];
            w_c_rd[0]   = rd_q[rd_ptr_q];
            w_c_rs1[0]  = rs1_q[rd_ptr_q];
            w_c_rs2[0]  = rs2_q[rd_ptr_q];
            w_c_we[0]   = we_q[rd_ptr_q];
            w_c_fu[0]   = fu_q[rd_ptr_q];
        end
        w_c_data[1] = data_q[w_idx1];
        w_c_rd[1]   = rd_q[w_idx1];
        w_c_rs1[1]  = rs1_q[w_idx1];
        w_c_rs2[1]  = rs2_q[w_idx1];
        w_c_we[1]   = we_q[w_idx1];
        w_c_fu[1]   = fu_q[w_idx1];
    end

    // per-slot readiness: operands available and the FU class accepting
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_c_rdy[k] = w_c_pres[k]
                       && src_free(w_c_rs1[k], rd_busy_i)
                       && src_free(w_c_rs2[k], rd_busy_i)
                       && fu_ready_i[w_c_fu[k]];
        end
    end

    // slot 1 must not read or overwrite slot 0's destination, nor share its FU
    always_comb begin
        w_hazard1 = 1'b0;
        if (w_c_we[0] && (w_c_rd[0] != 5'd0)) begin
            if ((w_c_rs1[1] == w_c_rd[0]) || (w_c_rs2[1] == w_c_rd[0])) begin
                w_hazard1 = 1'b1;
            end
            if (w_c_we[1] && (w_c_rd[1] == w_c_rd[0])) begin
                w_hazard1 = 1'b1;
            end
        end
        if (w_c_fu[1] == w_c_fu[0]) begin
            w_hazard1 = 1'b1;
        end
    end

    assign w_iss[0] = w_live && w_c_rdy[0];

    generate
        if (ISSUE_WIDTH == 2) begin : g_dual
            assign w_iss[1] = w_iss[0] && w_c_rdy[1] && !w_hazard1;
        end else begin : g_single
            assign w_iss[1] = 1'b0;
        end
    endgenerate

    // bookkeeping: stored entries popped and whether the enqueue is written
    always_comb begin
        w_pop_cnt = c_cnt_w'(w_iss[0] && !w_byp) + c_cnt_w'(w_iss[1]);
        w_enq_wr  = bus.enq_valid_i && w_enq_ready && !(w_byp && w_iss[0]);
    end

    // next pointer/count values; flush empties the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_enq_wr) begin
                wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            end
            rd_ptr_d = rd_ptr_q + w_pop_cnt[c_ptr_w-1:0];
            count_d  = count_q + c_cnt_w'(w_enq_wr) - w_pop_cnt;
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry write on accepted, non-bypassed enqueue
    always_ff @(posedge clk_i) begin
        if (w_enq_wr) begin
            data_q[wr_ptr_q] <= bus.enq_data_i;
            rd_q[wr_ptr_q]   <= bus.enq_rd_i;
            rs1_q[wr_ptr_q]  <= bus.enq_rs1_i;
            rs2_q[wr_ptr_q]  <= bus.enq_rs2_i;
            we_q[wr_ptr_q]   <= bus.enq_we_i;
            fu_q[wr_ptr_q]   <= bus.enq_fu_i;
        end
    end

    // drive issue bus; non-issued slots carry zeros
    always_comb begin
        bus.issue_valid_o = '0;
        bus.issue_data_o  = '0;
        bus.issue_rd_o    = '0;
        bus.issue_we_o    = '0;
        bus.issue_fu_o    = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (w_iss[k]) begin
                bus.issue_valid_o[k] = 1'b1;
                bus.issue_data_o[k]  = w_c_data[k];
                bus.issue_rd_o[k]    = w_c_rd[k];
                bus.issue_we_o[k]    = w_c_we[k];
                bus.issue_fu_o[k]    = w_c_fu[k];
            end
        end
    end

    assign bus.enq_ready_o = w_enq_ready;
    assign count_o         = count_q;
    assign stall_o         = !rst_i && (count_q != '0) && (w_iss == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_multi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_issue_queue
// Description : Scoreboard bench for multi_issue_queue. A queue-of-entries
//               reference model predicts every cycle's outputs; a monitor
//               compares them against the DUT. Honours ISSUE_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_issue_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [1:0]  fu;
    } ent_t;

    typedef struct packed {
        logic [1:0]       v;
        logic [1:0][63:0] d;
        logic [1:0][4:0]  rd;
        logic [1:0]       we;
        logic [1:0][1:0]  fu;
        logic [3:0]       cnt;
        logic             stall;
        logic             rdy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] rd_busy;
    logic [3:0]  fu_ready;
    logic [3:0]  count_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    ent_t mq[$];
    exp_t exp_q[$];
    ent_t none;

    multi_issue_queue_if #(.ISSUE_WIDTH(2), .DATA_WIDTH(64), .NR_FU(4)) bus ();

    multi_issue_queue #(
        .DEPTH(DEPTH), .ISSUE_WIDTH(2), .DATA_WIDTH(64), .NR_FU(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .rd_busy_i  (rd_busy),
        .fu_ready_i (fu_ready),
        .count_o    (count_o),
        .stall_o    (stall_o),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic ent_t mk(input int rd, input int rs1, input int rs2,
                                input bit we, input int fu);
        ent_t e;
        e.data = {$urandom(), $urandom()};
        e.rd   = 5'(rd);
        e.rs1  = 5'(rs1);
        e.rs2  = 5'(rs2);
        e.we   = we;
        e.fu   = 2'(fu);
        return e;
    endfunction

    // an instruction may go when neither source is pending and its FU is ready
    function automatic bit can_go(input ent_t e, input logic [31:0] busy, input logic [3:0] fur);
        bit s1, s2;
        s1 = (e.rs1 == 0) || !busy[e.rs1];
        s2 = (e.rs2 == 0) || !busy[e.rs2];
        return s1 && s2 && fur[e.fu];
    endfunction

    // the younger instruction must not depend on or collide with the older one
    function automatic bit pair_ok(input ent_t a, input ent_t b);
        if (a.fu == b.fu) return 0;
        if (a.we && a.rd != 0) begin
            if (b.rs1 == a.rd || b.rs2 == a.rd) return 0;
            if (b.we && b.rd == a.rd) return 0;
        end
        return 1;
    endfunction

    // one clock cycle: drive inputs, predict outputs, advance the model
    task automatic step(input bit r, input bit f, input bit ev, input ent_t e,
                        input logic [31:0] busy, input logic [3:0] fur);
        exp_t x;
        ent_t c0, c1;
        bit   p0, p1, byp, i0, i1, accept;
        int   sz;
        @(negedge clk);
        rst             = r;
        flush           = f;
        rd_busy         = busy;
        fu_ready        = fur;
        bus.enq_valid_i = ev;
        bus.enq_data_i  = e.data;
        bus.enq_rd_i    = e.rd;
        bus.enq_rs1_i   = e.rs1;
        bus.enq_rs2_i   = e.rs2;
        bus.enq_we_i    = e.we;
        bus.enq_fu_i    = e.fu;

        sz    = mq.size();
        x     = '0;
        x.cnt = 4'(sz);
        x.rdy = !r && !f && (sz < DEPTH);
        byp   = 0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        byp   = !r && !f && ev && (sz == 0);
`endif
        p0 = (sz > 0) || byp;
        c0 = byp ? e : ((sz > 0) ? mq[0] : none);
        p1 = (sz > 1);
        c1 = p1 ? mq[1] : none;
        i0 = !r && !f && p0 && can_go(c0, busy, fur);
        i1 = i0 && p1 && can_go(c1, busy, fur) && pair_ok(c0, c1);
        if (i0) begin
            x.v[0] = 1'b1; x.d[0] = c0.data; x.rd[0] = c0.rd; x.we[0] = c0.we; x.fu[0] = c0.fu;
        end
        if (i1) begin
            x.v[1] = 1'b1; x.d[1] = c1.data; x.rd[1] = c1.rd; x.we[1] = c1.we; x.fu[1] = c1.fu;
        end
        x.stall = !r && (sz > 0) && !i0;
        exp_q.push_back(x);

        accept = ev && x.rdy && !(byp && i0);
        if (r || f) begin
            mq.delete();
        end else begin
            if (i0 && !byp) void'(mq.pop_front());
            if (i1) void'(mq.pop_front());
            if (accept) mq.push_back(e);
        end
    endtask

    // monitor: compare DUT against the oldest prediction each cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("issue_valid", 64'(bus.issue_valid_o), 64'(x.v));
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("issue_data[%0d]", k), bus.issue_data_o[k], x.d[k]);
                    chk($sformatf("issue_rd[%0d]", k), 64'(bus.issue_rd_o[k]), 64'(x.rd[k]));
                    chk($sformatf("issue_we[%0d]", k), 64'(bus.issue_we_o[k]), 64'(x.we[k]));
                    chk($sformatf("issue_fu[%0d]", k), 64'(bus.issue_fu_o[k]), 64'(x.fu[k]));
                end
                chk("count", 64'(count_o), 64'(x.cnt));
                chk("stall", 64'(stall_o), 64'(x.stall));
                chk("enq_ready", 64'(bus.enq_ready_o), 64'(x.rdy));
            end
        end
    end

    initial begin
        ent_t e;
        none            = '0;
        rst             = 1'b1;
        flush           = 1'b0;
        rd_busy         = '0;
        fu_ready        = '0;
        bus.enq_valid_i = 1'b0;
        bus.enq_data_i  = '0;
        bus.enq_rd_i    = '0;
        bus.enq_rs1_i   = '0;
        bus.enq_rs2_i   = '0;
        bus.enq_we_i    = 1'b0;
        bus.enq_fu_i    = '0;
        repeat (2) @(posedge clk);

        // reset cycle seen by the scoreboard
        step(1, 0, 0, none, 0, 4'hF);

        // fill with independent ALU/LSU alternating entries while units idle
        for (int i = 0; i < 8; i++) step(0, 0, 1, mk(i + 1, 0, 0, 1, i % 2), 0, 4'h0);
        // full: enqueue refused, queue stalls
        step(0, 0, 1, mk(20, 0, 0, 1, 0), 0, 4'h0);
        // units ready: two per cycle until empty
        for (int i = 0; i < 5; i++) step(0, 0, 0, none, 0, 4'hF);

        // RAW on x5 between slot 0 and slot 1
        step(0, 0, 1, mk(5, 0, 0, 1, 0), 0, 4'h0);
        step(0, 0, 1, mk(6, 5, 0, 1, 1), 0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, none, 0, 4'hF);

        // x0 never hazards
        step(0, 0, 1, mk(0, 0, 0, 1, 0), 0, 4'h0);
        step(0, 0, 1, mk(7, 0, 0, 1, 1), 0, 4'h0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, none, 0, 4'hF);

        // flush with five queued and an enqueue pending
        for (int i = 0; i < 5; i++) step(0, 0, 1, mk(i + 10, 0, 0, 1, i % 4), 0, 4'h0);
        step(0, 1, 1, mk(30, 0, 0, 1, 2), 0, 4'hF);
        for (int i = 0; i < 2; i++) step(0, 0, 0, none, 0, 4'hF);

        // empty-queue enqueue of a ready instruction
        step(0, 0, 1, mk(3, 0, 0, 1, 2), 0, 4'hF);
        for (int i = 0; i < 2; i++) step(0, 0, 0, none, 0, 4'hF);

        // mid-operation reset, then enqueue right after it falls
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(i + 1, 0, 0, 1, 0), 0, 4'h0);
        step(1, 0, 1, mk(9, 0, 0, 1, 1), 0, 4'hF);
        step(0, 0, 1, mk(9, 0, 0, 1, 1), 0, 4'h0);
        step(0, 0, 0, none, 0, 4'hF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            e = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) < 60,
                 e,
                 $urandom() & $urandom() & 32'h0000_00FF,
                 4'($urandom() | $urandom()));
        end

        @(negedge clk);
        #5;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
